// File: rtl/cfg_stream_loader.sv
// Buffered configuration loader: accepts (addr, data, bcast, last) words over ready/valid,
// queues them in a FIFO and issues one per cycle to a selected tile channel or to all.
module cfg_stream_loader #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int NUM_CH = 4,
  parameter int CH_LSB = 24
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_bcast,
  input  logic              in_last,
  input  logic              pause_in,
  input  logic              restart_in,
  output logic [NUM_CH-1:0] config_en_out,
  output logic [ADDR_W-1:0] config_addr_out,
  output logic [DATA_W-1:0] config_data_out,
  output logic              config_done_out,
  output logic [15:0]       word_count_out,
  output logic              err_out
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int AW   = $clog2(DEPTH);
  localparam int W    = ADDR_W + DATA_W + 2;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t            state, state_next;
  logic [W-1:0]      mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              fifo_full, fifo_empty, push, pop;
  logic [W-1:0]      head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              head_bcast, head_last, ch_ok;
  logic [CH_W-1:0]   ch;
  logic [NUM_CH-1:0] onehot, target;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Gating with reset_in keeps ready low for the whole reset pulse, even before any edge.
  assign in_ready = ((state == IDLE) || (state == LOAD)) && !fifo_full && !reset_in;
  assign push     = in_valid && in_ready;
  assign pop      = !fifo_empty && !pause_in;

  assign head       = mem[rd_ptr[AW-1:0]];
  assign head_addr  = head[W-1 -: ADDR_W];
  assign head_data  = head[DATA_W+1:2];
  assign head_bcast = head[1];
  assign head_last  = head[0];
  assign ch         = head_addr[CH_LSB +: CH_W];
  assign ch_ok      = head_bcast || ({1'b0, ch} < (CH_W+1)'(NUM_CH));

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_onehot
    assign onehot[gi] = (ch == CH_W'(gi));
  end

  assign target = head_bcast ? '1 : onehot;

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_addr, in_data, in_bcast, in_last};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (push) state_next = in_last ? DRAIN : LOAD;
      LOAD:    if (push && in_last) state_next = DRAIN;
      DRAIN:   if (pop && head_last) state_next = DONE;
      DONE:    if (restart_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      config_en_out   <= '0;
      config_addr_out <= '0;
      config_data_out <= '0;
      config_done_out <= 1'b0;
      word_count_out  <= '0;
      err_out         <= 1'b0;
    end else begin
      state           <= state_next;
      config_done_out <= (state_next == DONE);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      config_en_out <= (pop && ch_ok) ? target : '0;
      if (pop && ch_ok) begin
        config_addr_out <= head_addr;
        config_data_out <= head_data;
        if (word_count_out != 16'hFFFF) word_count_out <= word_count_out + 16'd1;
      end
      if (pop && !ch_ok) err_out <= 1'b1;
      // The FIFO is empty in DONE, so the clear never races an increment.
      if ((state == DONE) && restart_in) word_count_out <= '0;
    end
  end

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Randomized bench for cfg_stream_loader with a queue-based reference model;
// three channels so channel field 3 exercises the out-of-range drop path.
module tb_cfg_stream_loader;

  localparam int DEPTH = 8;
  localparam int NCH   = 3;
  localparam int LSB   = 24;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        bcast;
    logic        last;
  } word_t;

  logic           clk_in = 1'b0;
  logic           reset_in = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [31:0]    in_addr = '0;
  logic [31:0]    in_data = '0;
  logic           in_bcast = 1'b0;
  logic           in_last = 1'b0;
  logic           pause_in = 1'b0;
  logic           restart_in = 1'b0;
  logic [NCH-1:0] config_en_out;
  logic [31:0]    config_addr_out;
  logic [31:0]    config_data_out;
  logic           config_done_out;
  logic [15:0]    word_count_out;
  logic           err_out;

  cfg_stream_loader #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .NUM_CH(NCH), .CH_LSB(LSB)
  ) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_bcast(in_bcast), .in_last(in_last),
    .pause_in(pause_in), .restart_in(restart_in),
    .config_en_out(config_en_out), .config_addr_out(config_addr_out),
    .config_data_out(config_data_out), .config_done_out(config_done_out),
    .word_count_out(word_count_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: words waiting to be issued, plus bitstream phase flags.
  word_t          mq[$];
  logic           m_accept, m_done, m_err;
  logic [15:0]    m_count;
  logic [31:0]    m_addr, m_data;
  logic [NCH-1:0] exp_en;
  logic           last_push;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_accept = 1'b1; m_done = 1'b0; m_err = 1'b0;
    m_count = '0; m_addr = '0; m_data = '0; exp_en = '0;
  endtask

  task automatic check_outputs();
    check("en",    64'(config_en_out),   64'(exp_en));
    check("addr",  64'(config_addr_out), 64'(m_addr));
    check("data",  64'(config_data_out), 64'(m_data));
    check("done",  64'(config_done_out), 64'(m_done));
    check("count", 64'(word_count_out),  64'(m_count));
    check("err",   64'(err_out),         64'(m_err));
  endtask

  // One clock: predict ready, take the edge, advance the model, compare outputs.
  task automatic step();
    logic  m_ready, do_pop, was_done, rs;
    word_t pw, w;
    int    ch;
    #1;
    m_ready = m_accept && !m_done && (mq.size() < DEPTH);
    check("in_ready", 64'(in_ready), 64'(m_ready));
    last_push = in_valid && m_ready;
    do_pop    = (mq.size() != 0) && !pause_in;
    was_done  = m_done;
    rs        = restart_in;
    pw        = '{addr: in_addr, data: in_data, bcast: in_bcast, last: in_last};
    @(posedge clk_in);
    #1;
    exp_en = '0;
    if (do_pop) begin
      w  = mq.pop_front();
      ch = int'(w.addr[LSB +: 2]);
      if (w.bcast) exp_en = '1;
      else if (ch < NCH) exp_en = NCH'(1 << ch);
      else m_err = 1'b1;
      if (exp_en != '0) begin
        m_addr = w.addr;
        m_data = w.data;
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      end
      if (w.last) m_done = 1'b1;
    end
    if (last_push) begin
      mq.push_back(pw);
      if (pw.last) m_accept = 1'b0;
    end
    if (rs && was_done) begin
      m_done = 1'b0; m_accept = 1'b1; m_count = '0;
    end
    check_outputs();
  endtask

  // mode 0: valid held; 1: random valid/pause; 2: valid held, 12-cycle pause.
  task automatic run_stream(input int n, input int mode, input logic fixed_first,
                            input logic [31:0] f_addr, input logic [31:0] f_data);
    word_t words[$];
    int    idx, cyc;
    logic  rs_sent;
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.addr  = ($urandom() & 32'hFCFF_FFFF) | (32'($urandom_range(0, 3)) << LSB);
      w.data  = $urandom();
      w.bcast = ($urandom_range(0, 7) == 0);
      w.last  = (i == n - 1);
      if (fixed_first && i == 0) begin
        w.addr = f_addr; w.data = f_data; w.bcast = 1'b0;
      end
      words.push_back(w);
    end
    idx = 0; cyc = 0; rs_sent = 1'b0;
    while (!m_done) begin
      if (cyc > 500) begin
        check("timeout", 64'd0, 64'd1);
        break;
      end
      in_valid   = (idx < n) && ((mode != 1) || ($urandom_range(0, 3) != 0));
      w          = words[(idx < n) ? idx : n - 1];
      in_addr    = w.addr; in_data = w.data; in_bcast = w.bcast; in_last = w.last;
      pause_in   = (mode == 1) ? ($urandom_range(0, 4) == 0) : ((mode == 2) && cyc >= 3 && cyc < 15);
      restart_in = (idx >= n) && !rs_sent;
      if (restart_in) rs_sent = 1'b1;
      step();
      if (last_push) idx++;
      cyc++;
    end
    in_valid = 1'b0; pause_in = 1'b0; restart_in = 1'b0;
    step();
    restart_in = 1'b1;
    step();
    restart_in = 1'b0;
    step();
  endtask

  initial begin
    model_reset();
    reset_in = 1'b1;
    repeat (4) @(posedge clk_in);
    #1;
    check("rst_ready", 64'(in_ready), 64'd0);
    check_outputs();
    reset_in = 1'b0;
    #1;
    check("rel_ready", 64'(in_ready), 64'd1);

    run_stream(1, 0, 1'b1, 32'h0100_0010, 32'hDEAD_BEEF);
    for (int b = 0; b < 4; b++) run_stream(20, 0, 1'b0, '0, '0);
    run_stream(20, 2, 1'b0, '0, '0);
    for (int b = 0; b < 6; b++) run_stream(15 + b, 1, 1'b0, '0, '0);

    // Buffer five words behind a pause, then reset asynchronously between edges.
    in_valid = 1'b1; pause_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_addr  = ($urandom() & 32'hFCFF_FFFF) | (32'($urandom_range(0, 2)) << LSB);
      in_data  = $urandom(); in_bcast = 1'b0; in_last = 1'b0;
      step();
    end
    in_valid = 1'b0;
    #2 reset_in = 1'b1;
    #1;
    model_reset();
    check("arst_ready", 64'(in_ready), 64'd0);
    check_outputs();
    repeat (2) @(posedge clk_in);
    #1 reset_in = 1'b0;
    pause_in = 1'b0;
    for (int i = 0; i < 4; i++) step();
    run_stream(6, 1, 1'b0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
